// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//
// Purpose
//   Turns rising edges on N_CH asynchronous input lines into a stream of
//   single events on one valid/ready port. Each line is resynchronised by a
//   3-flop chain (r1, r2, r3), and a rising edge (r2 & ~r3) is latched as a
//   pending event. A round-robin scheduler hands the pending events to the
//   output port one at a time.
//
// Ports
//   clk        in   1      system clock, all logic on posedge
//   rst        in   1      synchronous reset, active-high
//   signal     in   N_CH   raw asynchronous input lines
//   ch_en      in   N_CH   per-channel enable; 0 blocks new pending events
//   evt_ready  in   1      consumer accepts the presented event
//   evt_valid  out  1      an event is presented on evt_id
//   evt_id     out  ID_W   channel number of the presented event
//   pending    out  N_CH   pending-event flags
//   ovf        out  N_CH   sticky lost-event flags
//   ovf_clr    in   1      single-cycle pulse, clears all ovf bits
//
// Handshake: an event transfers on a posedge where evt_valid=1 and
// evt_ready=1. While evt_valid=1 and evt_ready=0 the event (evt_id) is held
// unchanged. evt_ready is ignored while evt_valid=0.
// -----------------------------------------------------------------------------
module edge_event_arbiter #(
   parameter  int N_CH = 4,
   localparam int ID_W = $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] signal,
   input  logic [N_CH-1:0] ch_en,
   input  logic            evt_ready,
   output logic            evt_valid,
   output logic [ID_W-1:0] evt_id,
   output logic [N_CH-1:0] pending,
   output logic [N_CH-1:0] ovf,
   input  logic            ovf_clr
);

   // The port state is the whole FSM; evt_valid is a direct decode of it,
   // so the state is always observable at the boundary.
   typedef enum logic {
      S_IDLE  = 1'b0,
      S_VALID = 1'b1
   } state_e;

   state_e          state_q, state_d;

   logic [N_CH-1:0] r1_q, r2_q, r3_q;
   logic [N_CH-1:0] pending_q, pending_d;
   logic [N_CH-1:0] ovf_q, ovf_d;
   logic [ID_W-1:0] evt_id_q, evt_id_d;
   logic [ID_W-1:0] ptr_q, ptr_d;

   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] arm;
   logic [N_CH-1:0] load_mask;
   logic            any_pending;
   logic            load;
   logic [ID_W-1:0] grant_id;
   logic [ID_W-1:0] grant_next;

   // --------------------------------------------------------------------------
   // Edge detection: r1 is the metastability catcher, r2/r3 form the history.
   // --------------------------------------------------------------------------
   assign rise = r2_q & ~r3_q;
   assign arm  = rise & ch_en;

   assign any_pending = |pending_q;

   // --------------------------------------------------------------------------
   // Round-robin select: first pending channel at or after ptr, wrapping.
   // --------------------------------------------------------------------------
   always_comb begin
      logic            found;
      int              idx;
      logic [ID_W-1:0] idx_v;
      found    = 1'b0;
      grant_id = '0;
      idx      = 0;
      idx_v    = '0;
      for (int off = 0; off < N_CH; off++) begin
         idx = int'(ptr_q) + off;
         if (idx >= N_CH) begin
            idx = idx - N_CH;
         end
         idx_v = ID_W'(idx);
         if (!found && pending_q[idx_v]) begin
            found    = 1'b1;
            grant_id = idx_v;
         end
      end
   end

   assign grant_next = (grant_id == ID_W'(N_CH - 1)) ? '0 : grant_id + ID_W'(1);

   // --------------------------------------------------------------------------
   // Output port FSM: next state and load decision.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_pending) begin
               load    = 1'b1;
               state_d = S_VALID;
            end
         end
         S_VALID: begin
            if (evt_ready) begin
               if (any_pending) begin
                  load = 1'b1;            // back-to-back reload
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Pending / overflow / id / pointer next-state.
   // A rise on the channel being loaded this edge re-arms its pending bit
   // (the old event leaves, the new one stays), so it is not an overflow.
   // --------------------------------------------------------------------------
   always_comb begin
      load_mask = '0;
      if (load) begin
         load_mask[grant_id] = 1'b1;
      end

      pending_d = (pending_q & ~load_mask) | arm;

      // Set has priority over the clear pulse.
      ovf_d = (ovf_clr ? '0 : ovf_q) | (arm & pending_q & ~load_mask);

      evt_id_d = load ? grant_id   : evt_id_q;
      ptr_d    = load ? grant_next : ptr_q;
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         r1_q      <= '0;
         r2_q      <= '0;
         r3_q      <= '0;
         pending_q <= '0;
         ovf_q     <= '0;
         evt_id_q  <= '0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         r1_q      <= signal;
         r2_q      <= r1_q;
         r3_q      <= r2_q;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         evt_id_q  <= evt_id_d;
         ptr_q     <= ptr_d;
      end
   end

   assign evt_valid = (state_q == S_VALID);
   assign evt_id    = evt_id_q;
   assign pending   = pending_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_edge_event_arbiter
//   Directed bench for edge_event_arbiter (N_CH=4). Inputs change 1 ns after
//   a rising clock edge and outputs are checked at the same point, so every
//   check sees the state produced by the edge just before it.
// -----------------------------------------------------------------------------
module tb_edge_event_arbiter;

   localparam int N_CH = 4;
   localparam int ID_W = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N_CH-1:0] signal;
   logic [N_CH-1:0] ch_en;
   logic            evt_ready;
   logic            evt_valid;
   logic [ID_W-1:0] evt_id;
   logic [N_CH-1:0] pending;
   logic [N_CH-1:0] ovf;
   logic            ovf_clr;

   int vectors    = 0;
   int miscompares = 0;

   // ---------------------------------------------------------------- clock
   always #5 clk = ~clk;

   edge_event_arbiter #(.N_CH(N_CH)) dut (
      .clk       (clk),
      .rst       (rst),
      .signal    (signal),
      .ch_en     (ch_en),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .pending   (pending),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   // ---------------------------------------------------------------- helpers
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_evt(input string tag, input logic [ID_W-1:0] id);
      check({tag, ".valid"}, 32'(evt_valid), 32'd1);
      check({tag, ".id"},    32'(evt_id),    32'(id));
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      rst       = 1'b1;
      signal    = 4'hF;
      ch_en     = 4'hF;
      evt_ready = 1'b1;
      ovf_clr   = 1'b0;

      // 1: reset values, then all four lines high -> ids 0,1,2,3
      tick(2);
      check("rst.valid",   32'(evt_valid), 32'd0);
      check("rst.pending", 32'(pending),   32'h0);
      check("rst.ovf",     32'(ovf),       32'h0);
      check("rst.id",      32'(evt_id),    32'h0);
      rst = 1'b0;
      tick(3);
      check("t1.valid_k2",   32'(evt_valid), 32'd0);
      check("t1.pending_k2", 32'(pending),   32'hF);
      tick(1); check_evt("t1.e0", 2'd0);
      check("t1.pending_e0", 32'(pending), 32'hE);
      tick(1); check_evt("t1.e1", 2'd1);
      tick(1); check_evt("t1.e2", 2'd2);
      tick(1); check_evt("t1.e3", 2'd3);
      tick(1); check("t1.idle", 32'(evt_valid), 32'd0);
      signal = 4'h0;
      tick(4);

      // 2: latency of a single ch2 edge (ptr is 0 here)
      signal = 4'b0100;
      tick(1); check("t2.pending_k",  32'(pending), 32'h0);
      tick(1); check("t2.pending_k1", 32'(pending), 32'h0);
      tick(1); check("t2.pending_k2", 32'(pending), 32'h4);
      check("t2.valid_k2", 32'(evt_valid), 32'd0);
      tick(1); check_evt("t2.k3", 2'd2);
      tick(1); check("t2.idle", 32'(evt_valid), 32'd0);
      signal = 4'h0;
      tick(4);

      // reset so the round-robin pointer starts from 0
      rst = 1'b1;
      tick(2);
      rst = 1'b0;

      // 3: round-robin ordering
      for (int rep = 0; rep < 2; rep++) begin
         signal = 4'b1001;
         tick(4); check_evt("t3.a0", 2'd0);
         tick(1); check_evt("t3.a3", 2'd3);
         tick(1); check("t3.a_idle", 32'(evt_valid), 32'd0);
         signal = 4'h0;
         tick(4);
      end
      signal = 4'b0010;               // moves ptr to 2
      tick(4); check_evt("t3.p1", 2'd1);
      tick(1); check("t3.p_idle", 32'(evt_valid), 32'd0);
      signal = 4'h0;
      tick(4);
      signal = 4'b1010;
      tick(4); check_evt("t3.b3", 2'd3);
      tick(1); check_evt("t3.b1", 2'd1);
      tick(1); check("t3.b_idle", 32'(evt_valid), 32'd0);
      signal = 4'h0;
      tick(4);

      // 4: backpressure. Three ch1 rises 4 cycles apart: the first sits on
      //    the port, the second is pending, the third is merged -> ovf[1].
      evt_ready = 1'b0;
      for (int r = 0; r < 3; r++) begin
         signal = 4'b0010;
         tick(2);
         signal = 4'h0;
         tick(2);
      end
      check_evt("t4.hold_a", 2'd1);
      check("t4.pending", 32'(pending), 32'h2);
      check("t4.ovf",     32'(ovf),     32'h2);
      tick(8);
      check_evt("t4.hold_b", 2'd1);
      evt_ready = 1'b1;
      tick(1); check_evt("t4.next", 2'd1);
      check("t4.pending_drained", 32'(pending), 32'h0);
      tick(1); check("t4.idle", 32'(evt_valid), 32'd0);
      check("t4.ovf_sticky", 32'(ovf), 32'h2);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      check("t4.ovf_clr", 32'(ovf), 32'h0);
      tick(2);

      // 5: ch0 rise on the same edge that ch0 is loaded from pending
      evt_ready = 1'b0;
      for (int r = 0; r < 2; r++) begin
         signal = 4'b0001;
         tick(2);
         signal = 4'h0;
         tick(2);
      end
      check_evt("t5.held", 2'd0);
      check("t5.pending_a", 32'(pending), 32'h1);
      signal = 4'b0001;
      tick(2);
      evt_ready = 1'b1;
      tick(1);
      check_evt("t5.reload", 2'd0);
      check("t5.pending_kept", 32'(pending), 32'h1);
      check("t5.no_ovf",       32'(ovf),     32'h0);
      signal = 4'h0;
      tick(1); check_evt("t5.second", 2'd0);
      check("t5.pending_done", 32'(pending), 32'h0);
      tick(1); check("t5.idle", 32'(evt_valid), 32'd0);
      tick(3);

      // 6a: masked channel produces nothing
      ch_en = 4'b1011;
      for (int r = 0; r < 2; r++) begin
         signal = 4'b0100;
         tick(2);
         signal = 4'h0;
         tick(2);
      end
      tick(3);
      check("t6.mask_valid",   32'(evt_valid), 32'd0);
      check("t6.mask_pending", 32'(pending),   32'h0);
      check("t6.mask_ovf",     32'(ovf),       32'h0);
      ch_en = 4'hF;

      // 6b: reset while an event is presented (ptr is 1 after test 5)
      evt_ready = 1'b0;
      signal    = 4'b1001;
      tick(4);
      check_evt("t6.pre_rst", 2'd3);
      check("t6.pre_rst_pending", 32'(pending), 32'h1);
      rst = 1'b1;
      tick(1);
      check("t6.rst_valid",   32'(evt_valid), 32'd0);
      check("t6.rst_pending", 32'(pending),   32'h0);
      check("t6.rst_id",      32'(evt_id),    32'h0);
      rst       = 1'b0;
      evt_ready = 1'b1;
      // lines still high: exactly one new event per line, ptr restarted at 0
      tick(4); check_evt("t6.post0", 2'd0);
      tick(1); check_evt("t6.post3", 2'd3);
      tick(1); check("t6.post_idle", 32'(evt_valid), 32'd0);
      tick(4); check("t6.no_more", 32'(evt_valid), 32'd0);
      signal = 4'h0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
